// File: rtl/sw_enc_pkg.sv
// sw_enc_pkg: shared types and helpers for the switch priority encoder.
//   db_state_e        - debounce FSM states (STABLE, SETTLING)
//   DEBOUNCE_DEFAULT  - default stable-cycle count (10 ms at 100 MHz)
//   multi_hot()       - true when two or more bits of a vector are set
package sw_enc_pkg;

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } db_state_e;

  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  // Operates on a 64-bit zero-extended vector so any N up to 64 can use it.
  function automatic logic multi_hot(input logic [63:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 64; i++) n += 32'(v[i]);
    return (n >= 2);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus whole-vector debounce.
//   clk     in  : system clock
//   reset   in  : synchronous, active-high
//   sw      in  : raw asynchronous switch inputs [N-1:0]
//   stable  out : settled switch vector [N-1:0]
// SW_ENC_DEBOUNCE_EN defined: FSM/counter require DEBOUNCE_CYCLES consecutive
// matching samples before stable commits. Undefined: stable follows the
// synchroniser output every cycle.
module sw_debounce
  import sw_enc_pkg::*;
#(
  parameter int N               = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw,
  output logic [N-1:0] stable
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("sw_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [N-1:0] s1, s2;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
    end
  end

`ifdef SW_ENC_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  db_state_e    state, state_d;
  logic [N-1:0] cand, cand_d, stable_d;
  logic [CW-1:0] cnt, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= STABLE;
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
    end else begin
      state  <= state_d;
      cand   <= cand_d;
      cnt    <= cnt_d;
      stable <= stable_d;
    end
  end

  // Any mismatch reloads the candidate from either state, so a bounce
  // restarts the count from zero.
  always_comb begin
    state_d  = state;
    cand_d   = cand;
    cnt_d    = cnt;
    stable_d = stable;
    if (s2 != cand) begin
      cand_d  = s2;
      cnt_d   = '0;
      state_d = SETTLING;
    end else if (state == SETTLING) begin
      cnt_d = cnt + CW'(1);
      if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = cand;
        state_d  = STABLE;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) stable <= '0;
    else       stable <= s2;
  end
`endif

endmodule

// File: rtl/sw_priority_encoder.sv
// sw_priority_encoder: debounced N-switch priority encoder.
//   clk     in  : system clock
//   reset   in  : synchronous, active-high
//   sw      in  : raw switch inputs [N-1:0]
//   idx     out : index of the winning set bit (0 when none set)
//   valid   out : at least one bit set in the settled vector
//   multi   out : two or more bits set in the settled vector
//   change  out : one-cycle pulse when idx/valid/multi take a new value
// PRIO_HIGH=1 picks the highest set index, 0 the lowest.
// Optional debounce is compiled in with SW_ENC_DEBOUNCE_EN.
module sw_priority_encoder
  import sw_enc_pkg::*;
#(
  parameter int N               = 16,
  parameter int IDX_W           = $clog2(N),
  parameter bit PRIO_HIGH       = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     sw,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  output logic             multi,
  output logic             change
);

  logic [N-1:0]     stable;
  logic [63:0]      stable_ext;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_valid, enc_multi;

  sw_debounce #(
    .N               (N),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_db (
    .clk    (clk),
    .reset  (reset),
    .sw     (sw),
    .stable (stable)
  );

  // Scan order makes the last hit the winner: ascending for high priority,
  // descending for low priority.
  always_comb begin
    enc_idx    = '0;
    stable_ext = '0;
    stable_ext[N-1:0] = stable;
    if (PRIO_HIGH) begin
      for (int i = 0; i < N; i++)
        if (stable[i]) enc_idx = IDX_W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (stable[i]) enc_idx = IDX_W'(i);
    end
    enc_valid = |stable;
    enc_multi = multi_hot(stable_ext);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx    <= '0;
      valid  <= 1'b0;
      multi  <= 1'b0;
      change <= 1'b0;
    end else begin
      idx    <= enc_idx;
      valid  <= enc_valid;
      multi  <= enc_multi;
      change <= (enc_idx != idx) || (enc_valid != valid) || (enc_multi != multi);
    end
  end

endmodule

// File: tb/tb_sw_priority_encoder.sv
// tb_sw_priority_encoder: three encoders share one switch bus
//   u_h: D=4, high priority   u_l: D=4, low priority   u_b: D=8, high priority
// Every edge all outputs are compared against a sample-history reference:
// the settled value is the latest switch value held for at least D+1
// consecutive samples, seen 3 edges after its last qualifying sample.
module tb_sw_priority_encoder;

`ifdef SW_ENC_DEBOUNCE_EN
  localparam int DH = 4;
  localparam int DB = 8;
`else
  localparam int DH = 0;
  localparam int DB = 0;
`endif
  localparam int LAT_H = DH + 3;
  localparam int LAT_B = DB + 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] sw = 16'hFFFF;
  logic [3:0]  idx_o [3];
  logic        valid_o [3], multi_o [3], change_o [3];

  always #5 clk = ~clk;

  sw_priority_encoder #(.N(16), .PRIO_HIGH(1'b1), .DEBOUNCE_CYCLES(4)) u_h (
    .clk(clk), .reset(reset), .sw(sw),
    .idx(idx_o[0]), .valid(valid_o[0]), .multi(multi_o[0]), .change(change_o[0]));
  sw_priority_encoder #(.N(16), .PRIO_HIGH(1'b0), .DEBOUNCE_CYCLES(4)) u_l (
    .clk(clk), .reset(reset), .sw(sw),
    .idx(idx_o[1]), .valid(valid_o[1]), .multi(multi_o[1]), .change(change_o[1]));
  sw_priority_encoder #(.N(16), .PRIO_HIGH(1'b1), .DEBOUNCE_CYCLES(8)) u_b (
    .clk(clk), .reset(reset), .sw(sw),
    .idx(idx_o[2]), .valid(valid_o[2]), .multi(multi_o[2]), .change(change_o[2]));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model state, one slot per DUT
  int          md [3] = '{DH, DH, DB};
  bit          ph [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] dl [3][3];
  logic [15:0] rv [3];
  int          rl [3];
  logic [15:0] settled [3];
  logic [3:0]  e_idx [3];
  logic        e_valid [3], e_multi [3], e_change [3];

  function automatic logic [3:0] ref_idx(input logic [15:0] v, input bit hi);
    if (v == 0) return 4'd0;
    if (hi) begin
      for (int i = 15; i >= 0; i--) if (v[i]) return 4'(i);
    end else begin
      for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
    end
    return 4'd0;
  endfunction

  function automatic int bits_set(input logic [15:0] v);
    int n = 0;
    for (int i = 0; i < 16; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic model_edge();
    logic [15:0] x;
    logic [3:0]  ni;
    logic        nv, nm;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        for (int k = 0; k < 3; k++) dl[d][k] = '0;
        rv[d] = '0; rl[d] = 1000; settled[d] = '0;
        e_idx[d] = '0; e_valid[d] = 1'b0; e_multi[d] = 1'b0; e_change[d] = 1'b0;
      end else begin
        x = dl[d][2];
        dl[d][2] = dl[d][1]; dl[d][1] = dl[d][0]; dl[d][0] = sw;
        if (x == rv[d]) begin
          if (rl[d] < 1000) rl[d]++;
        end else begin
          rv[d] = x; rl[d] = 1;
        end
        if (rl[d] >= md[d] + 1) settled[d] = rv[d];
        ni = ref_idx(settled[d], ph[d]);
        nv = (settled[d] != 0);
        nm = (bits_set(settled[d]) >= 2);
        e_change[d] = (ni != e_idx[d]) || (nv != e_valid[d]) || (nm != e_multi[d]);
        e_idx[d] = ni; e_valid[d] = nv; e_multi[d] = nm;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("idx%0d", d),    32'(idx_o[d]),    32'(e_idx[d]));
      chk($sformatf("valid%0d", d),  32'(valid_o[d]),  32'(e_valid[d]));
      chk($sformatf("multi%0d", d),  32'(multi_o[d]),  32'(e_multi[d]));
      chk($sformatf("change%0d", d), 32'(change_o[d]), 32'(e_change[d]));
    end
  endtask

  logic [15:0] rnd;

  initial begin
    // reset held 3 cycles with all switches on
    repeat (3) step();
    chk("rst_idx", 32'(idx_o[0]), 0);
    chk("rst_valid", 32'(valid_o[0]), 0);
    chk("rst_change", 32'(change_o[2]), 0);

    // single switch; release and new value land on the same edge 0
    reset = 1'b0; sw = 16'h0020;
    repeat (LAT_H) step();
    chk("single_early", 32'(valid_o[0]), 0);
    step();
    chk("single_idx", 32'(idx_o[0]), 5);
    chk("single_valid", 32'(valid_o[0]), 1);
    chk("single_multi", 32'(multi_o[0]), 0);
    chk("single_chg", 32'(change_o[0]), 1);
    step();
    chk("single_chg_end", 32'(change_o[0]), 0);

    // priority and multi
    sw = 16'h8101;
    repeat (LAT_B + 1) step();
    chk("prio_hi", 32'(idx_o[0]), 15);
    chk("prio_lo", 32'(idx_o[1]), 0);
    chk("multi_hi", 32'(multi_o[0]), 1);
    chk("multi_lo", 32'(multi_o[1]), 1);

    // bounce: toggle every 3 cycles for 30 cycles, then hold
    for (int s = 0; s < 10; s++) begin
      sw = (s % 2 == 0) ? 16'h0004 : 16'h0000;
      repeat (3) step();
    end
    sw = 16'h0004;
    repeat (LAT_B + 1) step();
    chk("bounce_chg", 32'(change_o[2]), 1);
    chk("bounce_idx", 32'(idx_o[2]), 2);
    step();
    chk("bounce_chg_end", 32'(change_o[2]), 0);

    // all off after idx=9
    sw = 16'h0200;
    repeat (LAT_B + 2) step();
    chk("pre_off_idx", 32'(idx_o[2]), 9);
    sw = 16'h0000;
    repeat (LAT_B + 1) step();
    chk("off_valid", 32'(valid_o[2]), 0);
    chk("off_idx", 32'(idx_o[2]), 0);
    chk("off_multi", 32'(multi_o[2]), 0);
    chk("off_chg", 32'(change_o[2]), 1);

    // random holds, including 1-cycle glitches and sparse values
    for (int s = 0; s < 250; s++) begin
      case ($urandom_range(0, 3))
        0:       rnd = 16'h0000;
        1:       rnd = 16'h0001 << $urandom_range(0, 15);
        default: rnd = 16'($urandom);
      endcase
      sw = rnd;
      repeat ($urandom_range(1, 14)) step();
    end

    // mid-settling reset discards the candidate and emits no pulse
    sw = 16'h0810;
    repeat (4) step();
    reset = 1'b1;
    repeat (2) step();
    chk("mid_rst_valid", 32'(valid_o[2]), 0);
    reset = 1'b0;
    repeat (LAT_B + 2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_priority_encoder.md
# sw_priority_encoder

Parametrised, clocked successor to the 16-switch LED encoder for the Basys 3 board. It takes an N-bit switch vector and synchronises it into the clock domain. It debounces the vector as a whole, priority-encodes the settled value into a binary index, and registers the result. It also reports `valid`, `multi` (more than one switch on) and a one-cycle `change` strobe for downstream display or control logic.

## Interface
- `N`, 16: number of switch inputs, 2..64.
- `IDX_W`, `$clog2(N)`: index width (derived; do not override).
- `PRIO_HIGH`, 1: 1 = highest set index wins; 0 = lowest set index wins.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required (10 ms at 100 MHz), ≥1.
- `clk` in 1: system clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high reset.
- `sw` in N: raw asynchronous switch inputs.
- `idx` out IDX_W: encoded index of the winning set bit.
- `valid` out 1: at least one bit set in the settled vector.
- `multi` out 1: two or more bits set in the settled vector.
- `change` out 1: single-cycle pulse when `idx`, `valid` or `multi` updates.

## Operation
- Two-flop synchroniser `s1`→`s2` on all N bits.
- Debounce FSM with states STABLE and SETTLING, candidate register `cand`, and counter `cnt` (width `$clog2(DEBOUNCE_CYCLES+1)`).
  - `s2 != cand`: `cand <= s2`, `cnt <= 0`, state → SETTLING. This applies from either state, so a bounce restarts the count.
  - SETTLING and `s2 == cand`: `cnt <= cnt+1`. On the DEBOUNCE_CYCLES-th consecutive match: `stable <= cand`, state → STABLE.
  - STABLE and `s2 == cand`: hold.
- Encoder is combinational on `stable` and registered into `idx`/`valid`/`multi`.
  - `stable == 0`: `idx = 0`, `valid = 0`, `multi = 0`.
  - Winner selection follows `PRIO_HIGH`.
  - `multi` = popcount(stable) ≥ 2.
- `change` = 1 in the same cycle the output registers take a value differing from their previous value; otherwise 0.
- Reset values: `idx=0`, `valid=0`, `multi=0`, `change=0`, `s1=s2=cand=stable=0`, `cnt=0`, state STABLE.
- Reset asserted mid-settling discards the candidate. No `change` pulse is produced by reset itself.

## Timing
- Edge 0 is the first edge that samples a new `sw` value held steady.
- With debounce: `cand` loads at edge 2, `stable` commits at edge D+2, and outputs plus `change` appear at edge D+3 (D = DEBOUNCE_CYCLES).
- Without debounce: `stable <= s2` at edge 2; outputs at edge 3.
- If `sw` changes again before commit, latency restarts from the new value. Intermediate values never reach the outputs.
- `change` is high for exactly one cycle per output update. Back-to-back commits are at least D+1 cycles apart, so pulses never merge.

## Configuration
- `SW_ENC_DEBOUNCE_EN` defined: debounce FSM, `cand` and `cnt` are compiled in, and `DEBOUNCE_CYCLES` applies.
- Not defined: FSM and counter are removed, `stable` is loaded from `s2` every cycle, and `DEBOUNCE_CYCLES` is ignored. Latency is a fixed 3 edges.

## Structure
- Shared package `sw_enc_pkg`:
  - debounce state enum (STABLE, SETTLING);
  - `DEBOUNCE_DEFAULT` constant;
  - popcount-≥2 function.
- Sub-module `sw_debounce`: N-bit synchroniser plus FSM/counter. Output is `stable`; the macro gates its internals.
- Top level holds the encoder and output registers.

## Test plan
- Reset: hold `reset` 3 cycles with `sw=16'hFFFF` → all outputs 0; after release, outputs update only at edge D+3.
- Single switch, D=4, PRIO_HIGH=1: `sw=16'h0020` → at edge 7, `idx=5`, `valid=1`, `multi=0`, `change` pulses one cycle.
- Priority and multi: `sw=16'h8101` with PRIO_HIGH=1 → `idx=15`, `multi=1`. With PRIO_HIGH=0 → `idx=0`, `multi=1`.
- Bounce: D=8, toggle `sw` between `16'h0004` and `0` every 3 cycles for 30 cycles, then hold `16'h0004` → no `change` during toggling; single pulse with `idx=2` at 11 edges after final hold start.
- All off after `idx=9`: `sw=0` → after D+3 edges, `valid=0`, `idx=0`, `multi=0`, one `change` pulse.
- Macro off: `sw=16'h0400` → `idx=10`, `valid=1` at edge 3; a 1-cycle glitch on `sw` yields a corresponding output change 3 edges later.
